// File: rtl/jk_register_bank_pkg.sv
// Shared constants for the JK register bank: mode encodings and event counter width.
package jk_register_bank_pkg;

  localparam logic [1:0] JKR_MODE_JK     = 2'b00;
  localparam logic [1:0] JKR_MODE_TOGGLE = 2'b01;
  localparam logic [1:0] JKR_MODE_LOAD   = 2'b10;
  localparam logic [1:0] JKR_MODE_SHIFT  = 2'b11;

  localparam int JKR_EVENT_W = 16;

endpackage

// File: rtl/jkr_bit_cell.sv
// One-bit next-state function of the JK register bank (combinational only).
module jkr_bit_cell
  import jk_register_bank_pkg::*;
(
  input  logic       q,
  input  logic       j,
  input  logic       k,
  input  logic       e,
  input  logic [1:0] mode,
  input  logic       shift_in,
  output logic       q_next
);

  always_comb begin
    q_next = q;
    if (e) begin
      case (mode)
        JKR_MODE_JK: begin
          case ({j, k})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        JKR_MODE_TOGGLE: q_next = j ? ~q : q;
        JKR_MODE_LOAD:   q_next = j;
        JKR_MODE_SHIFT:  q_next = shift_in;
        default:         q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK cells with per-bit enable, run-time mode and change flag.
// Optional saturating change-event counter on _events when JKR_EVENT_COUNT_EN is defined.
module jk_register_bank
  import jk_register_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic [WIDTH-1:0] _J,
  input  logic [WIDTH-1:0] _K,
  input  logic [WIDTH-1:0] _E,
  input  logic [1:0]       _mode,
  output logic [WIDTH-1:0] _Q,
  output logic [WIDTH-1:0] _QNOT,
  output logic             _changed,
`ifdef JKR_EVENT_COUNT_EN
  output logic [JKR_EVENT_W-1:0] _events,
`endif
  output logic [WIDTH-1:0] _return
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] shift_in;
  logic             changed_reg;
  logic             will_change;

  // Shift chain taps pre-edge state, so a disabled bit still feeds its upper neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_lsb
      assign shift_in[i] = _K[0];
    end else begin : g_upper
      assign shift_in[i] = q_reg[i-1];
    end

    jkr_bit_cell u_cell (
      .q        (q_reg[i]),
      .j        (_J[i]),
      .k        (_K[i]),
      .e        (_E[i]),
      .mode     (_mode),
      .shift_in (shift_in[i]),
      .q_next   (q_next[i])
    );
  end

  assign will_change = (q_next != q_reg);

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      q_reg       <= '0;
      changed_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      changed_reg <= will_change;
    end
  end

`ifdef JKR_EVENT_COUNT_EN
  logic [JKR_EVENT_W-1:0] events_reg;

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      events_reg <= '0;
    end else if (will_change && (events_reg != '1)) begin
      events_reg <= events_reg + 1'b1;
    end
  end

  assign _events = events_reg;
`endif

  assign _Q       = q_reg;
  assign _QNOT    = ~q_reg;
  assign _return  = q_reg;
  assign _changed = changed_reg;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed self-checking bench for jk_register_bank (WIDTH=8); the event counter
// section runs only when JKR_EVENT_COUNT_EN is defined.
module tb_jk_register_bank;
  import jk_register_bank_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] j_in, k_in, e_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q, q_not, ret;
  logic             changed;
`ifdef JKR_EVENT_COUNT_EN
  logic [15:0]      events;
`endif

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  jk_register_bank #(.WIDTH(WIDTH)) dut (
    ._clock   (clk),
    ._reset   (rst_n),
    ._J       (j_in),
    ._K       (k_in),
    ._E       (e_in),
    ._mode    (mode),
    ._Q       (q),
    ._QNOT    (q_not),
    ._changed (changed),
`ifdef JKR_EVENT_COUNT_EN
    ._events  (events),
`endif
    ._return  (ret)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1ns after the next rising edge.
  task automatic step(input logic [1:0] m, input logic [7:0] j, input logic [7:0] k,
                      input logic [7:0] e);
    @(negedge clk);
    mode = m; j_in = j; k_in = k; e_in = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic [7:0] exp_q, input logic exp_chg);
    check({tag, "_q"}, {8'h00, q}, {8'h00, exp_q});
    check({tag, "_qnot"}, {8'h00, q_not}, {8'h00, ~exp_q});
    check({tag, "_ret"}, {8'h00, ret}, {8'h00, exp_q});
    check({tag, "_chg"}, {15'h0, changed}, {15'h0, exp_chg});
  endtask

  initial begin
    rst_n = 1'b0; mode = JKR_MODE_JK; j_in = '0; k_in = '0; e_in = '0;
    #12;
    check_q("reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(JKR_MODE_LOAD, 8'hA5, 8'h00, 8'hFF);
    check_q("load_a5", 8'hA5, 1'b1);

    // Asynchronous reset mid-cycle, with a pending load that must be discarded.
    #2;
    mode = JKR_MODE_LOAD; j_in = 8'hFF; e_in = 8'hFF;
    rst_n = 1'b0;
    #1;
    check_q("async_rst", 8'h00, 1'b0);
`ifdef JKR_EVENT_COUNT_EN
    check("async_rst_events", events, 16'h0000);
`endif
    @(posedge clk);
    #1;
    check_q("rst_hold", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(JKR_MODE_LOAD, 8'h0F, 8'h00, 8'hFF);
    check_q("load_0f", 8'h0F, 1'b1);
    step(JKR_MODE_JK, 8'hF0, 8'h3C, 8'hFF);
    check_q("jk", 8'hF3, 1'b1);
    step(JKR_MODE_JK, 8'h00, 8'h00, 8'hFF);
    check_q("jk_hold", 8'hF3, 1'b0);

    step(JKR_MODE_LOAD, 8'h00, 8'h00, 8'hFF);
    check_q("clear", 8'h00, 1'b1);
    step(JKR_MODE_TOGGLE, 8'hFF, 8'hFF, 8'h0F);
    check_q("tog1", 8'h0F, 1'b1);
    step(JKR_MODE_TOGGLE, 8'hFF, 8'h00, 8'h0F);
    check_q("tog2", 8'h00, 1'b1);
    step(JKR_MODE_TOGGLE, 8'hFF, 8'hAA, 8'h0F);
    check_q("tog3", 8'h0F, 1'b1);
    step(JKR_MODE_TOGGLE, 8'h00, 8'hFF, 8'hFF);
    check_q("tog_j0", 8'h0F, 1'b0);

    step(JKR_MODE_LOAD, 8'h5A, 8'hFF, 8'hFF);
    check_q("load_5a", 8'h5A, 1'b1);
    step(JKR_MODE_LOAD, 8'h5A, 8'h00, 8'hFF);
    check_q("load_same", 8'h5A, 1'b0);
    step(JKR_MODE_LOAD, 8'hFF, 8'h00, 8'h00);
    check_q("en_off", 8'h5A, 1'b0);
    step(JKR_MODE_LOAD, 8'h00, 8'h00, 8'h0F);
    check_q("load_partial", 8'h50, 1'b1);

    step(JKR_MODE_LOAD, 8'h81, 8'h00, 8'hFF);
    check_q("load_81", 8'h81, 1'b1);
    step(JKR_MODE_SHIFT, 8'h00, 8'h01, 8'hFF);
    check_q("shift1", 8'h03, 1'b1);
    step(JKR_MODE_SHIFT, 8'hFF, 8'h00, 8'hFD);
    check_q("shift_dis", 8'h06, 1'b1);
    step(JKR_MODE_JK, 8'h00, 8'hFF, 8'hFF);
    check_q("jk_reset_all", 8'h00, 1'b1);

`ifdef JKR_EVENT_COUNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ev_rst", events, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(JKR_MODE_TOGGLE, 8'h01, 8'h00, 8'h01);
    check("ev_three", events, 16'd3);
    step(JKR_MODE_TOGGLE, 8'h00, 8'h00, 8'hFF);
    check("ev_nochg", events, 16'd3);
    for (int i = 0; i < 70000; i++) step(JKR_MODE_TOGGLE, 8'h01, 8'h00, 8'h01);
    check("ev_sat", events, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("ev_async_rst", events, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
